// File: rtl/mips_data_mem_responder_if.sv
// Data-port bus between the MIPS core (master) and its memory responder (slave).
// Byte lane k of the data arrays maps to byte address mem_addr+k.
interface mips_data_mem_responder_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [7:0]  mem_data_in  [0:3];
    logic        halted;
    logic [7:0]  mem_data_out [0:3];
    logic        mem_ready;
    logic        mem_busy;
    logic        mem_err;

    modport master (
        output mem_req, mem_addr, mem_write_en, mem_data_in, halted,
        input  mem_data_out, mem_ready, mem_busy, mem_err
    );

    modport slave (
        input  mem_req, mem_addr, mem_write_en, mem_data_in, halted,
        output mem_data_out, mem_ready, mem_busy, mem_err
    );
endinterface

// File: rtl/mips_data_mem_responder.sv
// Fixed-latency word memory for the MIPS data port: accepts one request at a time,
// answers after LATENCY cycles with a one-cycle ready pulse and an error flag.
module mips_data_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                            clk,
    input  logic                            rst_b,
    mips_data_mem_responder_if.slave        bus
);
    localparam int AW    = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    logic [31:0]      r_addr;
    logic             r_we;
    logic [7:0]       r_wdata [0:3];
    logic             r_err;
    logic [7:0]       r_dout  [0:3];
    logic [7:0]       r_mem   [0:MEM_WORDS-1][0:3];

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_commit;
    logic [31:0]      w_addr;
    logic             w_we;
    logic             w_err;
    logic [7:0]       w_wdata [0:3];
    logic [AW-1:0]    w_idx;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(MEM_WORDS));
    endfunction

    // With LATENCY=1 the RESP entry happens on the accept edge, so the request
    // fields come straight from the bus in IDLE and from the latches otherwise.
    always_comb begin
        w_accept = (r_state == IDLE) && bus.mem_req && !bus.halted;
        w_addr   = (r_state == IDLE) ? bus.mem_addr     : r_addr;
        w_we     = (r_state == IDLE) ? bus.mem_write_en : r_we;
        w_err    = (r_state == IDLE) ? addr_err(bus.mem_addr) : r_err;
        for (int k = 0; k < 4; k++) begin
            w_wdata[k] = (r_state == IDLE) ? bus.mem_data_in[k] : r_wdata[k];
        end
        w_idx = w_addr[AW+1:2];
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = WAIT;
                        w_next_cnt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == CNT_W'(1)) w_next_state = RESP;
                else                    w_next_cnt   = r_cnt - CNT_W'(1);
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A reset held across the edge must not let a pending write reach the array.
    assign w_enter_resp = (w_next_state == RESP) && !rst_b;
    assign w_commit     = w_enter_resp && w_we && !w_err;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            for (int k = 0; k < 4; k++) r_dout[k] <= 8'h00;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) r_err <= addr_err(bus.mem_addr);
            if (w_enter_resp && (w_err || !w_we)) begin
                for (int k = 0; k < 4; k++) r_dout[k] <= w_err ? 8'h00 : r_mem[w_idx][k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= bus.mem_addr;
            r_we   <= bus.mem_write_en;
            for (int k = 0; k < 4; k++) r_wdata[k] <= bus.mem_data_in[k];
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) r_mem[w_idx][k] <= w_wdata[k];
        end
    end

    always_comb begin
        bus.mem_ready = (r_state == RESP);
        bus.mem_busy  = (r_state != IDLE);
        bus.mem_err   = (r_state == RESP) && r_err;
        for (int k = 0; k < 4; k++) bus.mem_data_out[k] = r_dout[k];
    end
endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Scoreboard bench for mips_data_mem_responder: directed and random requests on a
// LATENCY=2 instance plus a short directed run on a LATENCY=1 instance.
module tb_mips_data_mem_responder;
    localparam int MEM_WORDS = 1024;
    localparam int LAT       = 2;

    logic clk   = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    mips_data_mem_responder_if bus();
    mips_data_mem_responder_if bus1();

    mips_data_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LAT)) dut (
        .clk(clk), .rst_b(rst_b), .bus(bus.slave)
    );
    mips_data_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .bus(bus1.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        int          rdy_cyc;
    } txn_t;

    txn_t        sb[$];
    logic [31:0] wlist[$];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] ref_dout = 32'h0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dout_of(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

    // Reference model: every negedge, decide whether the DUT should be busy or answering.
    always @(negedge clk) begin
        if (mon_en) begin
            txn_t t;
            bit   exp_busy;
            bit   e;
            while (sb.size() > 0 && sb[0].rdy_cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL ready_missing addr=%h expected_cycle=%0d now=%0d",
                         sb[0].addr, sb[0].rdy_cyc, cyc);
                void'(sb.pop_front());
            end
            exp_busy = (sb.size() > 0) && (cyc >= sb[0].rdy_cyc - LAT + 1);
            chk("busy", 32'(bus.mem_busy), 32'(exp_busy));
            if (sb.size() > 0 && sb[0].rdy_cyc == cyc) begin
                t = sb.pop_front();
                e = (t.addr % 4 != 0) || (t.addr / 4 >= MEM_WORDS);
                if (e) begin
                    ref_dout = 32'h0;
                end else if (t.we) begin
                    for (int k = 0; k < 4; k++) ref_mem[t.addr + k] = t.data[31-8*k -: 8];
                end else begin
                    for (int k = 0; k < 4; k++) ref_dout[31-8*k -: 8] = ref_mem[t.addr + k];
                end
                chk("ready", 32'(bus.mem_ready), 32'd1);
                chk("err", 32'(bus.mem_err), 32'(e));
                chk("dout", dout_of(bus.mem_data_out[0], bus.mem_data_out[1],
                                    bus.mem_data_out[2], bus.mem_data_out[3]), ref_dout);
            end else begin
                chk("ready_idle", 32'(bus.mem_ready), 32'd0);
                chk("err_idle", 32'(bus.mem_err), 32'd0);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus.mem_addr     = a;
        bus.mem_write_en = w;
        for (int k = 0; k < 4; k++) bus.mem_data_in[k] = d[31-8*k -: 8];
        bus.mem_req      = 1'b1;
    endtask

    // b2b: called in the RESP cycle of the previous request with mem_req still held.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input bit b2b, input bit keep, input int halt_cyc);
        txn_t t;
        bit   done;
        done = 1'b0;
        if (!b2b) begin
            @(negedge clk);
            #1;
        end
        drive(a, w, d);
        if (halt_cyc > 0) begin
            bus.halted = 1'b1;
            repeat (halt_cyc) begin
                @(negedge clk);
                #1;
                chk("halt_busy", 32'(bus.mem_busy), 32'd0);
            end
            bus.halted = 1'b0;
        end
        t.addr = a; t.we = w; t.data = d;
        t.rdy_cyc = cyc + LAT + (b2b ? 1 : 0);
        sb.push_back(t);
        if (w && a[1:0] == 2'b00 && a < 32'(4 * MEM_WORDS)) wlist.push_back(a);
        for (int i = 0; i < LAT + 10 && !done; i++) begin
            @(negedge clk);
            #1;
            done = bus.mem_ready;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout addr=%h actual=no_ready required=ready", a);
        end
        if (!keep) bus.mem_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        bit          prev_keep;
        bit          keep;
        int          r;

        bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_write_en = 1'b0; bus.halted = 1'b0;
        bus1.mem_req = 1'b0; bus1.mem_addr = '0; bus1.mem_write_en = 1'b0; bus1.halted = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_data_in[k]  = 8'h00;
            bus1.mem_data_in[k] = 8'h00;
        end

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_busy", 32'(bus.mem_busy), 32'd0);
        chk("rst_err", 32'(bus.mem_err), 32'd0);
        chk("rst_dout", dout_of(bus.mem_data_out[0], bus.mem_data_out[1],
                                bus.mem_data_out[2], bus.mem_data_out[3]), 32'h0);
        #1;
        rst_b  = 1'b0;
        mon_en = 1'b1;

        // Aligned write/read, misaligned write, out-of-range read, last valid word.
        issue(32'h10, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        issue(32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        issue(32'h13, 1'b1, 32'h11223344, 1'b0, 1'b0, 0);
        issue(32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        issue(32'h1000, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        issue(32'hFFC, 1'b1, 32'h5A6B7C8D, 1'b0, 1'b0, 0);
        issue(32'hFFC, 1'b0, 32'h0, 1'b0, 1'b0, 0);

        // Back-to-back write then read of 0x20 with mem_req held through ready.
        issue(32'h20, 1'b1, 32'h01020304, 1'b0, 1'b1, 0);
        issue(32'h20, 1'b0, 32'h0, 1'b1, 1'b0, 0);

        // Reset during WAIT of a write: nothing commits, no ready follows.
        @(negedge clk);
        #1;
        drive(32'h20, 1'b1, 32'hAABBCCDD);
        begin
            txn_t t;
            t.addr = 32'h20; t.we = 1'b1; t.data = 32'hAABBCCDD; t.rdy_cyc = cyc + LAT;
            sb.push_back(t);
        end
        @(negedge clk);
        #1;
        rst_b = 1'b1;
        sb.delete();
        ref_dout = 32'h0;
        #1;
        chk("midrst_busy", 32'(bus.mem_busy), 32'd0);
        chk("midrst_ready", 32'(bus.mem_ready), 32'd0);
        bus.mem_req = 1'b0;
        @(negedge clk);
        #1;
        rst_b = 1'b0;
        repeat (4) @(negedge clk);
        issue(32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 0);

        // Halted for 5 cycles with a pending request.
        issue(32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 5);

        // Random traffic against the reference model.
        prev_keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            d = $urandom;
            if (r < 4 || wlist.size() == 0) begin
                a = 32'($urandom_range(0, 63)) * 4;
                w = 1'b1;
            end else if (r < 7) begin
                a = wlist[$urandom_range(0, wlist.size() - 1)];
                w = 1'b0;
            end else if (r < 8) begin
                a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                w = 1'($urandom_range(0, 1));
            end else begin
                a = $urandom | 32'h0000_1000;
                w = 1'($urandom_range(0, 1));
            end
            keep = (i != 39) && ($urandom_range(0, 3) == 0);
            issue(a, w, d, prev_keep, keep,
                  (!prev_keep && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
            prev_keep = keep;
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;

        // LATENCY=1 instance: ready in the cycle right after acceptance.
        @(negedge clk);
        #1;
        bus1.mem_addr = 32'h40; bus1.mem_write_en = 1'b1;
        for (int k = 0; k < 4; k++) bus1.mem_data_in[k] = 8'(32'hCAFEF00D >> (24 - 8 * k));
        bus1.mem_req = 1'b1;
        chk("l1_ready_before", 32'(bus1.mem_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("l1_wr_ready", 32'(bus1.mem_ready), 32'd1);
        chk("l1_wr_err", 32'(bus1.mem_err), 32'd0);
        bus1.mem_req = 1'b0;
        @(negedge clk);
        #1;
        chk("l1_idle_ready", 32'(bus1.mem_ready), 32'd0);
        chk("l1_idle_busy", 32'(bus1.mem_busy), 32'd0);
        bus1.mem_write_en = 1'b0;
        bus1.mem_req = 1'b1;
        @(negedge clk);
        #1;
        chk("l1_rd_ready", 32'(bus1.mem_ready), 32'd1);
        chk("l1_rd_dout", dout_of(bus1.mem_data_out[0], bus1.mem_data_out[1],
                                  bus1.mem_data_out[2], bus1.mem_data_out[3]), 32'hCAFEF00D);
        bus1.mem_req = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_data_mem_responder.md
Name: mips_data_mem_responder

Overview:
- Memory-side responder for the MIPS core's data port. It accepts word-wide read and write requests that the core issues on mem_addr, mem_data_in and mem_write_en, and returns read data on mem_data_out.
- Each request is serviced after a configurable latency from an internal word-organised byte array. Completion is signalled with a one-cycle ready pulse, which the core uses as a stall/handshake.
- Sits between mips_core and the testbench memory image, replacing the zero-latency behavioural memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words stored. Valid byte range is 0 to 4*MEM_WORDS-1.
- LATENCY, 2, cycles from request acceptance to the mem_ready pulse. Must be at least 1.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst_b  input  1  asynchronous, active-high reset. The port keeps the codebase name; it is active-high.
- mem_req  input  1  request valid. The core holds it until it sees mem_ready.
- mem_addr  input  32  byte address of the word.
- mem_write_en  input  1  1 = write, 0 = read. Sampled with mem_req.
- mem_data_in  input  8 x [0:3]  write data. Element k goes to byte address mem_addr+k.
- halted  input  1  core halted; new requests are not accepted while it is high.
- mem_data_out  output  8 x [0:3]  read data. Element k comes from byte address mem_addr+k.
- mem_ready  output  1  one-cycle completion pulse.
- mem_busy  output  1  high while a request is in flight.
- mem_err  output  1  valid only with mem_ready. Flags a misaligned or out-of-range request.

Behaviour:
- Reset (async, rst_b=1):
  - state=IDLE; mem_ready=0, mem_busy=0, mem_err=0, mem_data_out all bytes 0; counter=0.
  - Array contents are not modified by reset.
- Reset mid-operation: the in-flight request is discarded. No write commits and no ready pulse follows.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Acceptance: mem_req=1 and halted=0 at a rising edge.
  - On acceptance, latch addr, write-enable and the four data bytes.
  - Compute err = (addr[1:0]!=0) or (addr[31:2] >= MEM_WORDS).
  - If LATENCY=1, go directly to RESP. Otherwise go to WAIT with counter=LATENCY-1.
- WAIT: if counter==1, go to RESP; else decrement the counter.
- Entering RESP (the same edge):
  - Write, no err: commit the 4 latched bytes to word addr[31:2].
  - Read, no err: load mem_data_out from that word.
  - err: no array change; mem_data_out is loaded with zeros.
- RESP: mem_ready=1 and mem_err=err for exactly this one cycle; the next edge returns to IDLE.
- Latency: with the accept edge at E, mem_ready is high during the cycle following edge E+LATENCY-1.
- mem_busy = (state != IDLE).
- mem_data_out is registered. It holds its value until the next RESP entry. A write request leaves mem_data_out unchanged.
- mem_req is ignored in WAIT and RESP. A request still held in the RESP cycle is accepted in IDLE at the following edge, so mem_busy is low for exactly one cycle between back-to-back requests.
- Read-after-write: a read accepted after a write completes returns the new data.
- halted: while in IDLE, mem_req is ignored. A request already in flight completes normally.
- Address arithmetic: the word index is addr[31:2]. No wrap-around; an out-of-range index sets err.

Test Plan:
- Aligned write then read (LATENCY=2):
  - Reset, then write {DE,AD,BE,EF} to 0x10. mem_ready pulses once, 2 cycles after the request cycle, with mem_err=0.
  - Then read 0x10. mem_data_out = [0]=DE, [1]=AD, [2]=BE, [3]=EF.
- Misaligned write: write {11,22,33,44} to 0x13.
  - ready pulses with mem_err=1 and mem_data_out=0.
  - A following read of 0x10 still returns DE AD BE EF.
- Out-of-range read: read 0x1000 with MEM_WORDS=1024. Required: mem_err=1, data all zero, busy low on the cycle after ready.
- Back-to-back requests: hold mem_req high across the ready cycle, alternating write 0x20 {01,02,03,04} and read 0x20.
  - The second request is accepted one cycle after ready.
  - The read returns 01 02 03 04.
  - mem_busy dips low for exactly one cycle between the two requests.
- Reset mid-request: assert rst_b during WAIT of a write to 0x20 of {AA,BB,CC,DD}.
  - Immediately: mem_busy=0 and mem_ready=0, and no ready pulse ever follows.
  - A later read of 0x20 returns 01 02 03 04.
- halted and LATENCY=1:
  - With halted=1 and mem_req=1 for 5 cycles, mem_busy stays 0. After halted drops, the request is accepted.
  - With LATENCY=1, mem_ready is high in the cycle right after acceptance.
